// File: rtl/axis_cpu_loader.sv
// AXI-Stream program loader: turns header+payload packets into write strobes
// for the CPU's instruction memory, immediates table and jump offsets table.
module axis_cpu_loader #(
    parameter int CODE_ADDR_WIDTH = 10,
    parameter int INST_WIDTH      = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [31:0]                s_axis_tdata,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,
    input  logic                       s_axis_tlast,
    input  logic                       cpu_idle,
    output logic                       cpu_hold,
    output logic                       inst_wr_en,
    output logic [CODE_ADDR_WIDTH-1:0] inst_wr_addr,
    output logic [INST_WIDTH-1:0]      inst_wr_data,
    output logic                       imm_wr_en,
    output logic [3:0]                 imm_wr_addr,
    output logic [31:0]                imm_wr_data,
    output logic                       jmp_off_wr_en,
    output logic [3:0]                 jmp_off_wr_addr,
    output logic [7:0]                 jmp_off_wr_data,
    output logic                       load_done,
    output logic                       load_err
);

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, FINISH} state_t;

    localparam logic [1:0]  TGT_INST   = 2'b00;
    localparam logic [1:0]  TGT_IMM    = 2'b01;
    localparam logic [1:0]  TGT_JMP    = 2'b10;
    localparam logic [1:0]  TGT_RSVD   = 2'b11;
    localparam logic [16:0] INST_LIMIT = 17'(1 << CODE_ADDR_WIDTH);
    localparam logic [16:0] TBL_LIMIT  = 17'd16;

    state_t      state, next_state;
    logic [1:0]  target_q, target_d;
    logic [16:0] addr_q, addr_d;
    logic        err_q, err_d;
    logic        wr_fire;
    logic        beat;
    logic [16:0] hdr_limit, cur_limit;

    assign beat = s_axis_tvalid && s_axis_tready;

    // The address counter is one bit wider than the header field so that
    // running past the table end is detected instead of wrapping to zero.
    always_comb begin
        next_state = state;
        target_d   = target_q;
        addr_d     = addr_q;
        err_d      = err_q;
        wr_fire    = 1'b0;
        hdr_limit  = (s_axis_tdata[31:30] == TGT_INST) ? INST_LIMIT : TBL_LIMIT;
        cur_limit  = (target_q == TGT_INST) ? INST_LIMIT : TBL_LIMIT;
        case (state)
            IDLE: begin
                if (beat) begin
                    target_d = s_axis_tdata[31:30];
                    addr_d   = {1'b0, s_axis_tdata[15:0]};
                    err_d    = (s_axis_tdata[31:30] == TGT_RSVD) ||
                               ({1'b0, s_axis_tdata[15:0]} >= hdr_limit);
                    if (s_axis_tlast)
                        next_state = FINISH;
                    else if (err_d)
                        next_state = DRAIN;
                    else
                        next_state = LOAD;
                end
            end
            LOAD: begin
                if (beat) begin
                    if (addr_q >= cur_limit) begin
                        err_d      = 1'b1;
                        next_state = s_axis_tlast ? FINISH : DRAIN;
                    end else begin
                        wr_fire = 1'b1;
                        addr_d  = addr_q + 17'd1;
                        if (s_axis_tlast)
                            next_state = FINISH;
                    end
                end
            end
            DRAIN: begin
                if (beat && s_axis_tlast)
                    next_state = FINISH;
            end
            FINISH: begin
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Every output is a register loaded from next-cycle decisions, so the
    // completion pulse lands in the same cycle as the final write strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            target_q        <= TGT_INST;
            addr_q          <= '0;
            err_q           <= 1'b0;
            s_axis_tready   <= 1'b0;
            cpu_hold        <= 1'b0;
            inst_wr_en      <= 1'b0;
            inst_wr_addr    <= '0;
            inst_wr_data    <= '0;
            imm_wr_en       <= 1'b0;
            imm_wr_addr     <= '0;
            imm_wr_data     <= '0;
            jmp_off_wr_en   <= 1'b0;
            jmp_off_wr_addr <= '0;
            jmp_off_wr_data <= '0;
            load_done       <= 1'b0;
            load_err        <= 1'b0;
        end else begin
            state         <= next_state;
            target_q      <= target_d;
            addr_q        <= addr_d;
            err_q         <= err_d;
            s_axis_tready <= ((next_state == IDLE) && cpu_idle) ||
                             (next_state == LOAD) || (next_state == DRAIN);
            inst_wr_en    <= 1'b0;
            imm_wr_en     <= 1'b0;
            jmp_off_wr_en <= 1'b0;
            load_done     <= (next_state == FINISH) && !err_d;
            load_err      <= (next_state == FINISH) && err_d;

            if ((state == IDLE) && beat)
                cpu_hold <= 1'b1;
            else if (state == FINISH)
                cpu_hold <= 1'b0;

            if (wr_fire) begin
                case (target_q)
                    TGT_INST: begin
                        inst_wr_en   <= 1'b1;
                        inst_wr_addr <= addr_q[CODE_ADDR_WIDTH-1:0];
                        inst_wr_data <= s_axis_tdata[INST_WIDTH-1:0];
                    end
                    TGT_IMM: begin
                        imm_wr_en   <= 1'b1;
                        imm_wr_addr <= addr_q[3:0];
                        imm_wr_data <= s_axis_tdata;
                    end
                    TGT_JMP: begin
                        jmp_off_wr_en   <= 1'b1;
                        jmp_off_wr_addr <= addr_q[3:0];
                        jmp_off_wr_data <= s_axis_tdata[7:0];
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_axis_cpu_loader.sv
// Bench for axis_cpu_loader: a packet-level model predicts writes, pulses and
// the hold window; a negedge monitor compares the DUT against it every cycle.
module tb_axis_cpu_loader;

    localparam int CAW = 10;
    localparam int IW  = 32;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [31:0]    s_axis_tdata = '0;
    logic           s_axis_tvalid = 1'b0;
    logic           s_axis_tready;
    logic           s_axis_tlast = 1'b0;
    logic           cpu_idle = 1'b1;
    logic           cpu_hold;
    logic           inst_wr_en;
    logic [CAW-1:0] inst_wr_addr;
    logic [IW-1:0]  inst_wr_data;
    logic           imm_wr_en;
    logic [3:0]     imm_wr_addr;
    logic [31:0]    imm_wr_data;
    logic           jmp_off_wr_en;
    logic [3:0]     jmp_off_wr_addr;
    logic [7:0]     jmp_off_wr_data;
    logic           load_done;
    logic           load_err;

    axis_cpu_loader #(.CODE_ADDR_WIDTH(CAW), .INST_WIDTH(IW)) dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
        .cpu_idle(cpu_idle), .cpu_hold(cpu_hold),
        .inst_wr_en(inst_wr_en), .inst_wr_addr(inst_wr_addr), .inst_wr_data(inst_wr_data),
        .imm_wr_en(imm_wr_en), .imm_wr_addr(imm_wr_addr), .imm_wr_data(imm_wr_data),
        .jmp_off_wr_en(jmp_off_wr_en), .jmp_off_wr_addr(jmp_off_wr_addr),
        .jmp_off_wr_data(jmp_off_wr_data),
        .load_done(load_done), .load_err(load_err)
    );

    typedef struct {
        logic [1:0]  tgt;
        int          addr;
        logic [31:0] data;
        int          widx;
    } wr_t;

    wr_t  exp_w[$];
    wr_t  obs_w[$];
    bit   exp_o[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   beat_cyc[64];
    int   last_cyc = 0;
    int   hold_from = 1;
    int   hold_to = 0;
    bit   chk_en = 1'b0;
    int   done_cnt = 0;
    int   err_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic reportMissing(input string name);
        tests++;
        fails++;
        $display("[TB] FAIL %s: DUT produced an event the model did not predict (cycle %0d)", name, cyc);
    endtask

    // Packet-level model: a write per payload word at start+i until the
    // target's limit is reached; any rejection turns the pulse into an error.
    task automatic modelPacket(input logic [31:0] words[$]);
        logic [1:0]  tgt;
        int          start, limit, a;
        bit          err;
        logic [31:0] d;
        wr_t         e;
        tgt   = words[0][31:30];
        start = int'(words[0][15:0]);
        limit = (tgt == 2'b00) ? (1 << CAW) : 16;
        err   = (tgt == 2'b11) || (start >= limit);
        for (int i = 1; i < words.size(); i++) begin
            if (!err) begin
                a = start + i - 1;
                if (a >= limit) begin
                    err = 1'b1;
                end else begin
                    d = words[i];
                    if (tgt == 2'b10) d = d & 32'h0000_00FF;
                    else if (tgt == 2'b00 && IW < 32) d = d & ((32'd1 << IW) - 32'd1);
                    e.tgt = tgt; e.addr = a; e.data = d; e.widx = i;
                    exp_w.push_back(e);
                end
            end
        end
        exp_o.push_back(err);
    endtask

    task automatic sendWord(input logic [31:0] d, input logic last, input int idx);
        int w;
        w = 0;
        @(negedge clk); #1;
        s_axis_tdata  = d;
        s_axis_tvalid = 1'b1;
        s_axis_tlast  = last;
        while (!s_axis_tready && w < 200) begin
            @(negedge clk); #1;
            w++;
        end
        if (!s_axis_tready) begin
            tests++;
            fails++;
            $display("[TB] FAIL beat_timeout: tready stayed 0, expected 1 for word %0d", idx);
            $display("[TB] %0d tests run, %0d failed", tests, fails);
            $finish;
        end
        beat_cyc[idx] = cyc;
        if (idx == 0) begin
            hold_to   = 1 << 30;
            hold_from = cyc + 1;
        end
        if (last) begin
            last_cyc = cyc;
            hold_to  = cyc + 1;
        end
        @(posedge clk);
    endtask

    task automatic endPacket();
        @(negedge clk); #1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("writes_outstanding", exp_w.size(), 0);
        checkOutput("pulse_outstanding", exp_o.size(), 0);
    endtask

    task automatic applyStimulus(input logic [31:0] words[$]);
        obs_w.delete();
        modelPacket(words);
        for (int i = 0; i < words.size(); i++)
            sendWord(words[i], i == words.size() - 1, i);
        endPacket();
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_tready"}, s_axis_tready, 0);
        checkOutput({tag, "_hold"}, cpu_hold, 0);
        checkOutput({tag, "_wr_en"}, {inst_wr_en, imm_wr_en, jmp_off_wr_en}, 0);
        checkOutput({tag, "_inst"}, {inst_wr_addr, inst_wr_data}, 0);
        checkOutput({tag, "_imm"}, {imm_wr_addr, imm_wr_data}, 0);
        checkOutput({tag, "_jmp"}, {jmp_off_wr_addr, jmp_off_wr_data}, 0);
        checkOutput({tag, "_pulse"}, {load_done, load_err}, 0);
    endtask

    // Per-cycle monitor: hold window, strobe exclusivity, write contents and
    // timing, and pulse kind/timing all come from the model's predictions.
    wr_t cmp_a, cmp_e;
    bit  cmp_o;
    int  cmp_n;
    always @(negedge clk) begin
        if (chk_en) begin
            cmp_n = int'(inst_wr_en) + int'(imm_wr_en) + int'(jmp_off_wr_en);
            checkOutput("wr_en_onehot", cmp_n <= 1, 1);
            checkOutput("cpu_hold", cpu_hold, (cyc >= hold_from) && (cyc <= hold_to));
            if (cmp_n > 0) begin
                if (inst_wr_en) begin
                    cmp_a.tgt = 2'b00; cmp_a.addr = int'(inst_wr_addr); cmp_a.data = 32'(inst_wr_data);
                end else if (imm_wr_en) begin
                    cmp_a.tgt = 2'b01; cmp_a.addr = int'(imm_wr_addr); cmp_a.data = imm_wr_data;
                end else begin
                    cmp_a.tgt = 2'b10; cmp_a.addr = int'(jmp_off_wr_addr); cmp_a.data = 32'(jmp_off_wr_data);
                end
                cmp_a.widx = 0;
                obs_w.push_back(cmp_a);
                if (exp_w.size() == 0) begin
                    reportMissing("unexpected_write");
                end else begin
                    cmp_e = exp_w.pop_front();
                    checkOutput("wr_target", cmp_a.tgt, cmp_e.tgt);
                    checkOutput("wr_addr", cmp_a.addr, cmp_e.addr);
                    checkOutput("wr_data", cmp_a.data, cmp_e.data);
                    checkOutput("wr_cycle", cyc, beat_cyc[cmp_e.widx] + 1);
                end
            end
            checkOutput("pulse_exclusive", load_done && load_err, 0);
            if (load_done || load_err) begin
                if (load_done) done_cnt++;
                if (load_err) err_cnt++;
                if (exp_o.size() == 0) begin
                    reportMissing("unexpected_pulse");
                end else begin
                    cmp_o = exp_o.pop_front();
                    checkOutput("pulse_is_err", load_err, cmp_o);
                    checkOutput("pulse_cycle", cyc, last_cyc + 1);
                end
            end
        end
    end

    logic [31:0] pkt[$];
    int          raise_cyc;
    int          base_done, base_err;

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        checkResetValues("reset");
        rst = 1'b0;
        chk_en = 1'b1;

        // Imm load with three entries starting at address 3.
        pkt = '{32'h4000_0003, 32'hDEAD_BEEF, 32'h0000_0001, 32'h0000_0002};
        applyStimulus(pkt);
        checkOutput("imm_count", obs_w.size(), 3);
        checkOutput("imm_first_addr", obs_w[0].addr, 3);
        checkOutput("imm_first_data", obs_w[0].data, 32'hDEAD_BEEF);
        checkOutput("imm_last_addr", obs_w[2].addr, 5);
        checkOutput("imm_done_cnt", done_cnt, 1);

        // Jump offset truncated to its low byte at the last table slot.
        pkt = '{32'h8000_000F, 32'h1234_56F9};
        applyStimulus(pkt);
        checkOutput("jmp_count", obs_w.size(), 1);
        checkOutput("jmp_addr", obs_w[0].addr, 15);
        checkOutput("jmp_data", obs_w[0].data, 32'hF9);
        checkOutput("jmp_done_cnt", done_cnt, 2);

        // Instruction load running off the end of a 1024-word memory.
        pkt = '{32'h0000_03FE, 32'hA000_0001, 32'hA000_0002, 32'hA000_0003, 32'hA000_0004};
        applyStimulus(pkt);
        checkOutput("ovf_count", obs_w.size(), 2);
        checkOutput("ovf_addr1", obs_w[1].addr, 32'h3FF);
        checkOutput("ovf_data1", obs_w[1].data, 32'hA000_0002);
        checkOutput("ovf_err_cnt", err_cnt, 1);

        // Reserved target: every beat accepted, nothing written.
        pkt = '{32'hC000_0000, 32'h1, 32'h2, 32'h3, 32'h4, 32'h5};
        applyStimulus(pkt);
        checkOutput("rsvd_count", obs_w.size(), 0);
        checkOutput("rsvd_err_cnt", err_cnt, 2);

        // Imm header past the table end with a payload: drained as an error.
        pkt = '{32'h4000_0010, 32'h7, 32'h8};
        applyStimulus(pkt);
        checkOutput("badstart_err_cnt", err_cnt, 3);

        // Backpressure while the CPU is busy, then a zero-length load.
        @(negedge clk); #1;
        cpu_idle = 1'b0;
        @(negedge clk); #1;
        s_axis_tdata  = 32'h4000_0005;
        s_axis_tvalid = 1'b1;
        s_axis_tlast  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            checkOutput("bp_tready", s_axis_tready, 0);
        end
        obs_w.delete();
        pkt = '{32'h4000_0005};
        modelPacket(pkt);
        cpu_idle  = 1'b1;
        raise_cyc = cyc;
        sendWord(32'h4000_0005, 1'b1, 0);
        checkOutput("bp_accept_cycle", beat_cyc[0], raise_cyc + 1);
        endPacket();
        checkOutput("zero_len_writes", obs_w.size(), 0);
        checkOutput("zero_len_done_cnt", done_cnt, 3);

        // Reset after two of four imm beats have been written.
        obs_w.delete();
        base_done = done_cnt;
        base_err  = err_cnt;
        pkt = '{32'h4000_0000, 32'h11, 32'h22, 32'h33, 32'h44};
        modelPacket(pkt);
        sendWord(pkt[0], 1'b0, 0);
        sendWord(pkt[1], 1'b0, 1);
        sendWord(pkt[2], 1'b0, 2);
        @(negedge clk); #1;
        rst = 1'b1;
        s_axis_tvalid = 1'b0;
        hold_to = cyc;
        exp_w.delete();
        exp_o.delete();
        @(negedge clk); #1;
        checkResetValues("midreset");
        rst = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        checkOutput("midreset_writes", obs_w.size(), 2);
        checkOutput("midreset_no_pulse", (done_cnt - base_done) + (err_cnt - base_err), 0);

        // Loader is usable again after the abort.
        pkt = '{32'h4000_0002, 32'hCAFE_0001};
        applyStimulus(pkt);
        checkOutput("after_reset_addr", obs_w[0].addr, 2);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
